sha256_round_sequencer: RTL and testbench

- Main FSM sequencer for one SHA-256 compression per start request.
- Reads the 16 message words from input memory into the W schedule and drives 64 rounds with the K index.
- Folds the working variables into H, then writes the 8-word digest to output memory after the last block.
- Sits between the host/padding logic and the round datapath; replaces free-running counter sequencing with a handshaked FSM.

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_round_sequencer.sv | 126 ++++++++++++
 tb/tb_sha256_round_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round sequencer: block geometry and FSM states.
package sha256_pkg;

    localparam int MSG_WORDS    = 16;
    localparam int ROUNDS       = 64;
    localparam int DIGEST_WORDS = 8;
    // One extra cycle drains the 1-cycle read latency of the input memory.
    localparam int LOAD_CYCLES  = MSG_WORDS + 1;
    localparam int CNT_W        = 7;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        ROUND,
        UPDATE,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/sha256_round_sequencer.sv
// Handshaked FSM that sequences one SHA-256 compression block: message load,
// 64 rounds, H update and, after the last block, the digest write-out.
module sha256_round_sequencer
    import sha256_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       first_block,
    input  logic       last_block,
    output logic       busy,
    output logic       block_done,
    output logic       done,
    output logic       in_mem_en,
    output logic [3:0] in_mem_addr,
    output logic       w_shift_en,
    output logic       w_sel,
    output logic       init_state,
    output logic       h_init_const,
    output logic       round_en,
    output logic [5:0] k_num,
    output logic       h_update,
    output logic       out_mem_en,
    output logic [2:0] out_mem_addr
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               first_q;
    logic               last_q;

    // State, counter and block-flag registers; counter restarts on every state entry.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees the values from before the edge, regardless of statement order.
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 7'd1;
            end
            // Flags are captured only when a block is accepted and held for its duration.
            if (state == IDLE && start) begin
                first_q <= first_block;
                last_q  <= last_block;
            end
        end
    end

    // Next-state logic; phase lengths come from the counter.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = LOAD;
            LOAD:    if (cnt == 7'(LOAD_CYCLES - 1))  state_nxt = ROUND;
            ROUND:   if (cnt == 7'(ROUNDS - 1))       state_nxt = UPDATE;
            UPDATE:  state_nxt = last_q ? WRITE : IDLE;
            WRITE:   if (cnt == 7'(DIGEST_WORDS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode from state and counter; everything is 0 in IDLE.
    always_comb begin
        busy         = (state != IDLE);
        block_done   = 1'b0;
        done         = 1'b0;
        in_mem_en    = 1'b0;
        in_mem_addr  = '0;
        w_shift_en   = 1'b0;
        w_sel        = 1'b0;
        init_state   = 1'b0;
        h_init_const = 1'b0;
        round_en     = 1'b0;
        k_num        = '0;
        h_update     = 1'b0;
        out_mem_en   = 1'b0;
        out_mem_addr = '0;
        case (state)
            INIT: begin
                init_state   = 1'b1;
                h_init_const = first_q;
            end
            LOAD: begin
                // Reads issue on cnt 0..15; data arrives one cycle later, so
                // the shift register advances on cnt 1..16.
                if (cnt < 7'(MSG_WORDS)) begin
                    in_mem_en   = 1'b1;
                    in_mem_addr = cnt[3:0];
                end
                if (cnt != '0) begin
                    w_shift_en = 1'b1;
                end
            end
            ROUND: begin
                round_en   = 1'b1;
                k_num      = cnt[5:0];
                w_shift_en = 1'b1;
                w_sel      = 1'b1;
            end
            UPDATE: begin
                h_update   = 1'b1;
                block_done = 1'b1;
            end
            WRITE: begin
                out_mem_en   = 1'b1;
                out_mem_addr = cnt[2:0];
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a block-timeline reference model (offset from accepted start).
module tb_sha256_round_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       first_block;
    logic       last_block;
    logic       busy;
    logic       block_done;
    logic       done;
    logic       in_mem_en;
    logic [3:0] in_mem_addr;
    logic       w_shift_en;
    logic       w_sel;
    logic       init_state;
    logic       h_init_const;
    logic       round_en;
    logic [5:0] k_num;
    logic       h_update;
    logic       out_mem_en;
    logic [2:0] out_mem_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: is a block in flight, when was it accepted, with which flags.
    bit m_active = 1'b0;
    int m_t0     = 0;
    bit m_first  = 1'b0;
    bit m_last   = 1'b0;
    bit chk_en   = 1'b0;

    int n_done   = 0;
    int n_bdone  = 0;
    int first_bd = 0;
    int last_bd  = 0;

    sha256_round_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .first_block  (first_block),
        .last_block   (last_block),
        .busy         (busy),
        .block_done   (block_done),
        .done         (done),
        .in_mem_en    (in_mem_en),
        .in_mem_addr  (in_mem_addr),
        .w_shift_en   (w_shift_en),
        .w_sel        (w_sel),
        .init_state   (init_state),
        .h_init_const (h_init_const),
        .round_en     (round_en),
        .k_num        (k_num),
        .h_update     (h_update),
        .out_mem_en   (out_mem_en),
        .out_mem_addr (out_mem_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the block timeline: offset d cycles after the start
    // was accepted. 1 = INIT, 2..18 = load, 19..82 = rounds, 83 = update,
    // 84..91 = digest write, 92 = done (last block only).
    function automatic logic [23:0] model_out(input bit act, input int d, input bit f, input bit l);
        logic       busy_e, bd_e, done_e, ime_e, wse_e, wsel_e, init_e, hic_e, re_e, hu_e, ome_e;
        logic [3:0] ima_e;
        logic [5:0] k_e;
        logic [2:0] oma_e;
        int         j;
        {busy_e, bd_e, done_e, ime_e, wse_e, wsel_e, init_e, hic_e, re_e, hu_e, ome_e} = '0;
        ima_e = '0;
        k_e   = '0;
        oma_e = '0;
        if (act) begin
            busy_e = 1'b1;
            if (d == 1) begin
                init_e = 1'b1;
                hic_e  = f;
            end else if (d >= 2 && d <= 18) begin
                j = d - 2;
                if (j <= 15) begin
                    ime_e = 1'b1;
                    ima_e = 4'(j);
                end
                if (j >= 1) wse_e = 1'b1;
            end else if (d >= 19 && d <= 82) begin
                re_e   = 1'b1;
                k_e    = 6'(d - 19);
                wse_e  = 1'b1;
                wsel_e = 1'b1;
            end else if (d == 83) begin
                hu_e = 1'b1;
                bd_e = 1'b1;
            end else if (l && d >= 84 && d <= 91) begin
                ome_e = 1'b1;
                oma_e = 3'(d - 84);
            end else if (l && d == 92) begin
                done_e = 1'b1;
            end
        end
        return {busy_e, bd_e, done_e, ime_e, ima_e, wse_e, wsel_e, init_e, hic_e,
                re_e, k_e, hu_e, ome_e, oma_e};
    endfunction

    // One clock cycle: drive inputs, compare outputs, advance the model, move to next negedge.
    task automatic step(input bit st, input bit fb, input bit lb, input bit rs);
        logic [23:0] obs;
        start       = st;
        first_block = fb;
        last_block  = lb;
        reset       = rs;
        obs = {busy, block_done, done, in_mem_en, in_mem_addr, w_shift_en, w_sel,
               init_state, h_init_const, round_en, k_num, h_update, out_mem_en, out_mem_addr};
        if (chk_en) begin
            check($sformatf("outputs@cyc%0d", cyc), 32'(obs),
                  32'(model_out(m_active, cyc - m_t0, m_first, m_last)));
        end
        if (done) n_done++;
        if (block_done) begin
            if (n_bdone == 0) first_bd = cyc;
            last_bd = cyc;
            n_bdone++;
        end
        if (!rs) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_first  = fb;
                m_last   = lb;
            end
        end else if ((cyc - m_t0) == (m_last ? 92 : 83)) begin
            m_active = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_counts();
        n_done  = 0;
        n_bdone = 0;
    endtask

    initial begin
        // Reset: first cycle unchecked (DUT state unknown), then reset held and checked.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_k_num", 32'(k_num), 32'd0);

        // Single-block message; flag inputs wander while busy and must be ignored.
        clear_counts();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 96; i++)
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
        check("single_done_count", 32'(n_done), 32'd1);
        check("single_block_done_count", 32'(n_bdone), 32'd1);

        // Two blocks: start during UPDATE is ignored, start in the IDLE cycle is taken.
        clear_counts();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 83; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 95; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("two_block_done_count", 32'(n_done), 32'd1);
        check("two_block_block_done_count", 32'(n_bdone), 32'd2);
        check("two_block_bd_spacing", 32'(last_bd - first_bd), 32'd84);

        // Start pulses at offsets 10 and 50 of a running block are not queued.
        clear_counts();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < 95; i++)
            step((i == 10) || (i == 50), 1'b1, 1'b1, 1'b1);
        check("busy_start_block_done_count", 32'(n_bdone), 32'd1);
        check("busy_start_done_count", 32'(n_done), 32'd0);

        // Reset at offset 40 (round 21) aborts the block with no pulses afterwards.
        clear_counts();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 40; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_k_num", 32'(k_num), 32'd21);
        check("abort_round_en", 32'(round_en), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_busy_after", 32'(busy), 32'd0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_done_count", 32'(n_done), 32'd0);
        check("abort_block_done_count", 32'(n_bdone), 32'd0);

        // Start held high with last=0: one block per 84 cycles (83 busy + 1 IDLE).
        clear_counts();
        for (int i = 0; i < 4 * 84; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("held_block_done_count", 32'(n_bdone), 32'd4);
        check("held_bd_spacing", 32'(last_bd - first_bd), 32'd252);
        for (int i = 0; i < 90; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional resets, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(7) == 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 $urandom_range(199) != 0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("final_idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
